// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bundle between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             hilo_rd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, hilo_rd,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, hilo_rd,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle on magnitudes,
// sign correction in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [WIDTH:0]     acc_reg;       // product high half / partial remainder
    logic [WIDTH-1:0]   lsw_reg;       // multiplier / quotient
    logic [WIDTH-1:0]   opnd_reg;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   a_orig_reg;
    logic               is_div_reg;
    logic               neg_reg;
    logic               sign_a_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] product, product_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign a_neg = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.b[WIDTH-1];
    assign a_abs = a_neg ? -bus.a : bus.a;
    assign b_abs = b_neg ? -bus.b : bus.b;

    assign mul_sum   = acc_reg + (lsw_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_reg[WIDTH-1:0], lsw_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_reg};

    assign product       = {acc_reg[WIDTH-1:0], lsw_reg};
    assign product_fixed = neg_reg ? -product : product;
    assign quo_fixed     = neg_reg ? -lsw_reg : lsw_reg;
    assign rem_fixed     = sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (count_reg == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            lsw_reg    <= '0;
            opnd_reg   <= '0;
            a_orig_reg <= '0;
            is_div_reg <= 1'b0;
            neg_reg    <= 1'b0;
            sign_a_reg <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        count_reg  <= CW'(WIDTH - 1);
                        acc_reg    <= '0;
                        lsw_reg    <= bus.op[1] ? a_abs : b_abs;
                        opnd_reg   <= bus.op[1] ? b_abs : a_abs;
                        a_orig_reg <= bus.a;
                        is_div_reg <= bus.op[1];
                        neg_reg    <= a_neg ^ b_neg;
                        sign_a_reg <= a_neg;
                        div0_reg   <= bus.op[1] & (bus.b == '0);
                    end else begin
                        // MTHI/MTLO only land when no operation is being launched
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                CALC: begin
                    count_reg <= count_reg - 1'b1;
                    if (is_div_reg) begin
                        if (!div_trial[WIDTH]) begin
                            acc_reg <= div_trial;
                            lsw_reg <= {lsw_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_reg <= div_shift;
                            lsw_reg <= {lsw_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_reg <= {1'b0, mul_sum[WIDTH:1]};
                        lsw_reg <= {mul_sum[0], lsw_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div_reg) begin
                        hi_reg <= product_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= product_fixed[WIDTH-1:0];
                    end else if (div0_reg) begin
                        hi_reg <= a_orig_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quo_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;
    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = done_reg;
    assign bus.stall = bus.busy & (bus.hilo_rd | bus.start);
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    muldiv_unit_if #(.WIDTH(W)) bus();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: latency WIDTH+1, done pulse after, writes only when idle.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0;
            m_rhi <= '0; m_rlo <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (bus.start) begin
                    {m_rhi, m_rlo} <= ref_result(bus.op, bus.a, bus.b);
                    m_left <= W + 1;
                end else begin
                    if (bus.hi_we) m_hi <= bus.wdata;
                    if (bus.lo_we) m_lo <= bus.wdata;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_rhi; m_lo <= m_rlo; m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("hi",    64'(bus.hi),    64'(m_hi));
        check("lo",    64'(bus.lo),    64'(m_lo));
        check("busy",  64'(bus.busy),  64'(m_left != 0));
        check("done",  64'(bus.done),  64'(m_done));
        check("stall", 64'(bus.stall), 64'((m_left != 0) & (bus.hilo_rd | bus.start)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input bit rand_rd);
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            if (rand_rd) begin
                bus.hilo_rd = ($urandom_range(0, 3) == 0);
                bus.start   = ($urandom_range(0, 7) == 0) && bus.busy;
            end
            tick();
            n++;
        end
        bus.hilo_rd = 1'b0;
        bus.start   = 1'b0;
        if (!bus.done) check("done_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        int n;
        logic [31:0] hold;
        bit saw_done;
        rst = 1'b1;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0; bus.hilo_rd = 0;
        tick(); tick();
        check("reset_hi", 64'(bus.hi), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        tick();

        // Pin the reference model to hand-computed values.
        check("model_multu", ref_result(2'b00, 32'hFFFFFFFF, 32'd2), {32'h1, 32'hFFFFFFFE});
        check("model_mult",  ref_result(2'b01, -32'sd3, 32'd5), {32'hFFFFFFFF, 32'hFFFFFFF1});
        check("model_div",   ref_result(2'b11, -32'sd7, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("model_ovf",   ref_result(2'b11, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});

        // 1: MULTU latency and done width
        launch(2'b00, 32'hFFFFFFFF, 32'd2);
        n = 0;
        while (bus.busy && n < 100) begin n++; tick(); end
        check("t1_busy_cycles", 64'(n), 64'(33));
        check("t1_done", 64'(bus.done), 64'(1));
        check("t1_hilo", {bus.hi, bus.lo}, {32'h1, 32'hFFFFFFFE});
        tick();
        check("t1_done_pulse", 64'(bus.done), 64'(0));

        // 2, 3: signed and corner divisions
        launch(2'b01, -32'sd3, 32'd5);          wait_done(0);
        check("t2_mult", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        launch(2'b11, -32'sd7, 32'd2);          wait_done(0);
        check("t2_div", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        launch(2'b11, 32'h80000000, 32'hFFFFFFFF); wait_done(0);
        check("t3_div_ovf", {bus.hi, bus.lo}, {32'h0, 32'h80000000});
        launch(2'b10, 32'd100, 32'd0);          wait_done(0);
        check("t3_div0", {bus.hi, bus.lo}, {32'h64, 32'hFFFFFFFF});

        // 4: start while busy ignored; restart in done cycle accepted
        launch(2'b10, 32'd100, 32'd7);
        tick(); tick(); tick();
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 3; bus.b = 3;
        #1 check("t4_stall", 64'(bus.stall), 64'(1));
        tick();
        bus.start = 1'b0;
        wait_done(0);
        check("t4_divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
        launch(2'b00, 32'd3, 32'd3);
        check("t4_restart_busy", 64'(bus.busy), 64'(1));
        wait_done(0);
        check("t4_multu", {bus.hi, bus.lo}, {32'd0, 32'd9});

        // 5: reset mid-operation
        launch(2'b00, 32'd6, 32'd7);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 64'(bus.busy), 64'(0));
        check("t5_rst_hilo", {bus.hi, bus.lo}, 64'(0));
        tick();
        rst = 1'b0;
        saw_done = 0;
        repeat (40) begin tick(); if (bus.done) saw_done = 1; end
        check("t5_no_done", 64'(saw_done), 64'(0));
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        tick();
        bus.lo_we = 1'b0;
        check("t5_mtlo", 64'(bus.lo), 64'h1234);

        // 6: MTHI ignored while busy, stall on hilo_rd
        hold = bus.hi;
        launch(2'b00, 32'd11, 32'd13);
        bus.hi_we = 1'b1; bus.wdata = 32'hAAAA5555;
        tick();
        bus.hi_we = 1'b0;
        check("t6_hi_hold", 64'(bus.hi), 64'(hold));
        bus.hilo_rd = 1'b1;
        #1 check("t6_stall", 64'(bus.stall), 64'(1));
        n = 0;
        while (!bus.done && n < 100) begin tick(); n++; end
        check("t6_stall_done", 64'(bus.stall), 64'(0));
        check("t6_result", {bus.hi, bus.lo}, {32'd0, 32'd143});
        bus.hilo_rd = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            repeat ($urandom_range(0, 3)) begin
                bus.hi_we   = $urandom_range(0, 1);
                bus.lo_we   = $urandom_range(0, 1);
                bus.wdata   = $urandom;
                bus.hilo_rd = $urandom_range(0, 1);
                tick();
            end
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 0;
            if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            bus.hi_we = $urandom_range(0, 1);
            bus.lo_we = $urandom_range(0, 1);
            bus.wdata = $urandom;
            launch(2'($urandom_range(0, 3)), ra, rb);
            bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hilo_rd = 1'b0;
            wait_done(1);
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
